// File: rtl/instr_issue_queue_if.sv
// Host-write and execute-issue handshakes of the instruction issue queue.
// valid/ready: a transfer happens on a rising edge where valid && ready are both high;
// once valid is raised, the payload stays stable and valid stays high until that transfer.
interface instr_issue_queue_if #(
  parameter int IW = 16
);
  logic [IW-1:0] wr_instr;
  logic          wr_valid;
  logic          wr_ready;
  logic [IW-1:0] issue_instr;
  logic          issue_valid;
  logic          issue_ready;

  modport slave (
    input  wr_instr,
    input  wr_valid,
    output wr_ready,
    output issue_instr,
    output issue_valid,
    input  issue_ready
  );

  modport master (
    output wr_instr,
    output wr_valid,
    input  wr_ready,
    input  issue_instr,
    input  issue_valid,
    output issue_ready
  );
endinterface

// File: rtl/instr_issue_queue.sv
// In-order instruction FIFO feeding a registered valid/ready issue port,
// sequenced by a run/step/halt control FSM.
module instr_issue_queue #(
  parameter int IW    = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_issue_queue_if.slave bus,
  input  logic              run_i,
  input  logic              step_i,
  input  logic              halt_i,
  input  logic              flush_i,
  output logic [AW:0]       fifo_count_o,
  output logic [1:0]        state_o,
  output logic [15:0]       issued_cnt_o
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STEP = 2'b10;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [IW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          valid_q, valid_d;
  logic [1:0]    state_q, state_d;
  logic [15:0]   issued_q, issued_d;

  logic flush_now;
  logic wr_ready;
  logic push;
  logic issue_en;
  logic load;
  logic consume;

  // Flush only takes effect in IDLE; it also blocks the host write that cycle.
  assign flush_now = flush_i && (state_q == S_IDLE);
  assign wr_ready  = (count_q != FULL) && !flush_now;
  assign push      = bus.wr_valid && wr_ready;
  assign issue_en  = ((state_q == S_RUN) || (state_q == S_STEP)) && !halt_i;
  assign load      = (count_q != '0) && (!valid_q || bus.issue_ready) && issue_en;
  assign consume   = valid_q && bus.issue_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    issued_d = issued_q;

    if (consume) begin
      issued_d = issued_q + 16'd1;
    end

    if (flush_now) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (load) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        instr_d  = mem_q[rd_ptr_q];
        valid_d  = 1'b1;
      end else if (consume) begin
        valid_d  = 1'b0;
      end
      case ({push, load})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // halt outranks run/step; STEP ends on the edge that loads its one instruction.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (halt_i)      state_d = S_IDLE;
        else if (run_i)  state_d = S_RUN;
        else if (step_i) state_d = S_STEP;
      end
      S_RUN: begin
        if (halt_i) state_d = S_IDLE;
      end
      S_STEP: begin
        if (halt_i || load) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      state_q  <= S_IDLE;
      issued_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      state_q  <= state_d;
      issued_q <= issued_d;
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.wr_instr;
    end
  end

  assign bus.wr_ready    = wr_ready;
  assign bus.issue_instr = instr_q;
  assign bus.issue_valid = valid_q;
  assign fifo_count_o    = count_q;
  assign state_o         = state_q;
  assign issued_cnt_o    = issued_q;

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed bench for instr_issue_queue: a per-cycle vector table plus hand-written
// sequences for full FIFO, output stall, and asynchronous reset.
module tb_instr_issue_queue;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STEP = 2'b10;

  logic        clk;
  logic        rst_n;
  logic        run, step, halt, flush;
  logic [3:0]  fifo_count;
  logic [1:0]  state;
  logic [15:0] issued_cnt;

  int total;
  int bad;

  logic [15:0] exp_q[$];

  typedef struct {
    logic        wv;
    logic [15:0] wi;
    logic        run;
    logic        step;
    logic        halt;
    logic        flush;
    logic        rdy;
    logic        ev;
    logic [15:0] ei;
    logic [3:0]  ec;
    logic [1:0]  es;
    logic        ewr;
    logic [15:0] en;
  } vec_t;

  vec_t vecs[$];

  instr_issue_queue_if #(.IW(16)) bus ();

  instr_issue_queue #(.IW(16), .DEPTH(8), .AW(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .run_i        (run),
    .step_i       (step),
    .halt_i       (halt),
    .flush_i      (flush),
    .fifo_count_o (fifo_count),
    .state_o      (state),
    .issued_cnt_o (issued_cnt)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic wv, input logic [15:0] wi, input logic r, input logic s,
                     input logic h, input logic f, input logic rdy, input logic ev,
                     input logic [15:0] ei, input logic [3:0] ec, input logic [1:0] es,
                     input logic ewr, input logic [15:0] en);
    vec_t v;
    v.wv = wv; v.wi = wi; v.run = r; v.step = s; v.halt = h; v.flush = f; v.rdy = rdy;
    v.ev = ev; v.ei = ei; v.ec = ec; v.es = es; v.ewr = ewr; v.en = en;
    vecs.push_back(v);
  endtask

  // Driver tasks
  task automatic idle_inputs();
    bus.wr_valid = 1'b0;
    bus.wr_instr = 16'h0000;
    run = 1'b0; step = 1'b0; halt = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_one(input logic [15:0] w);
    bus.wr_valid = 1'b1;
    bus.wr_instr = w;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  // Scoreboard drain: each valid cycle with ready=1 is consumed on the next edge.
  task automatic drain(input string name, input int max_cycles);
    for (int c = 0; c < max_cycles; c++) begin
      if (exp_q.size() == 0 && !bus.issue_valid) break;
      if (bus.issue_valid) begin
        if (exp_q.size() == 0) begin
          chk({name, "_extra_issue"}, {16'h0, bus.issue_instr}, 32'hFFFF_FFFF);
        end else begin
          chk({name, "_order"}, {16'h0, bus.issue_instr}, {16'h0, exp_q.pop_front()});
        end
      end
      tick();
    end
    chk({name, "_left"}, exp_q.size(), 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle_inputs();
    bus.issue_ready = 1'b1;
    #12;
    rst_n = 1'b1;
    #1;
    chk("rst_valid", {31'h0, bus.issue_valid}, 0);
    chk("rst_instr", {16'h0, bus.issue_instr}, 0);
    chk("rst_count", {28'h0, fifo_count}, 0);
    chk("rst_state", {30'h0, state}, {30'h0, S_IDLE});
    chk("rst_issued", {16'h0, issued_cnt}, 0);
    chk("rst_wr_ready", {31'h0, bus.wr_ready}, 1);
    tick();

    // wv wi run step halt flush rdy | ev ei ec es ewr en
    // In-order run of three writes
    add(1, 16'h0A51, 0,0,0,0,1, 0, 16'h0000, 1, S_IDLE, 1, 0);
    add(1, 16'hB012, 0,0,0,0,1, 0, 16'h0000, 2, S_IDLE, 1, 0);
    add(1, 16'h1013, 0,0,0,0,1, 0, 16'h0000, 3, S_IDLE, 1, 0);
    add(0, 16'h0000, 1,0,0,0,1, 0, 16'h0000, 3, S_RUN,  1, 0);
    add(0, 16'h0000, 0,0,0,0,1, 1, 16'h0A51, 2, S_RUN,  1, 0);
    add(0, 16'h0000, 0,0,0,0,1, 1, 16'hB012, 1, S_RUN,  1, 1);
    add(0, 16'h0000, 0,0,0,0,1, 1, 16'h1013, 0, S_RUN,  1, 2);
    add(0, 16'h0000, 0,0,0,0,1, 0, 16'h1013, 0, S_RUN,  1, 3);
    add(0, 16'h0000, 0,0,0,0,1, 0, 16'h1013, 0, S_RUN,  1, 3);
    // Single-step, including step waiting on an empty FIFO
    add(0, 16'h0000, 0,0,1,0,1, 0, 16'h1013, 0, S_IDLE, 1, 3);
    add(1, 16'h2001, 0,0,0,0,1, 0, 16'h1013, 1, S_IDLE, 1, 3);
    add(1, 16'h2002, 0,0,0,0,1, 0, 16'h1013, 2, S_IDLE, 1, 3);
    add(0, 16'h0000, 0,1,0,0,1, 0, 16'h1013, 2, S_STEP, 1, 3);
    add(0, 16'h0000, 0,0,0,0,1, 1, 16'h2001, 1, S_IDLE, 1, 3);
    add(0, 16'h0000, 0,0,0,0,1, 0, 16'h2001, 1, S_IDLE, 1, 4);
    add(0, 16'h0000, 0,1,0,0,1, 0, 16'h2001, 1, S_STEP, 1, 4);
    add(0, 16'h0000, 0,0,0,0,1, 1, 16'h2002, 0, S_IDLE, 1, 4);
    add(0, 16'h0000, 0,0,0,0,1, 0, 16'h2002, 0, S_IDLE, 1, 5);
    add(0, 16'h0000, 0,1,0,0,1, 0, 16'h2002, 0, S_STEP, 1, 5);
    add(0, 16'h0000, 0,0,0,0,1, 0, 16'h2002, 0, S_STEP, 1, 5);
    add(1, 16'h2003, 0,0,0,0,1, 0, 16'h2002, 1, S_STEP, 1, 5);
    add(0, 16'h0000, 0,0,0,0,1, 1, 16'h2003, 0, S_IDLE, 1, 5);
    add(0, 16'h0000, 0,0,0,0,1, 0, 16'h2003, 0, S_IDLE, 1, 6);
    // halt+run while stalled, drain held output, flush with concurrent write
    add(1, 16'h3001, 0,0,0,0,0, 0, 16'h2003, 1, S_IDLE, 1, 6);
    add(1, 16'h3002, 0,0,0,0,0, 0, 16'h2003, 2, S_IDLE, 1, 6);
    add(1, 16'h3003, 0,0,0,0,0, 0, 16'h2003, 3, S_IDLE, 1, 6);
    add(0, 16'h0000, 1,0,0,0,0, 0, 16'h2003, 3, S_RUN,  1, 6);
    add(0, 16'h0000, 0,0,0,0,0, 1, 16'h3001, 2, S_RUN,  1, 6);
    add(0, 16'h0000, 0,0,0,1,0, 1, 16'h3001, 2, S_RUN,  1, 6);
    add(0, 16'h0000, 1,0,1,0,0, 1, 16'h3001, 2, S_IDLE, 1, 6);
    add(0, 16'h0000, 0,0,0,0,1, 0, 16'h3001, 2, S_IDLE, 1, 7);
    add(1, 16'h3FFF, 0,0,0,1,1, 0, 16'h3001, 0, S_IDLE, 0, 7);
    add(0, 16'h0000, 0,0,0,0,1, 0, 16'h3001, 0, S_IDLE, 1, 7);
    // Flush clears a held issue_valid in IDLE
    add(1, 16'h3101, 0,0,0,0,0, 0, 16'h3001, 1, S_IDLE, 1, 7);
    add(0, 16'h0000, 0,1,0,0,0, 0, 16'h3001, 1, S_STEP, 1, 7);
    add(0, 16'h0000, 0,0,0,0,0, 1, 16'h3101, 0, S_IDLE, 1, 7);
    add(0, 16'h0000, 0,0,0,1,0, 0, 16'h3101, 0, S_IDLE, 0, 7);
    add(0, 16'h0000, 0,0,0,0,1, 0, 16'h3101, 0, S_IDLE, 1, 7);

    foreach (vecs[i]) begin
      bus.wr_valid    = vecs[i].wv;
      bus.wr_instr    = vecs[i].wi;
      run             = vecs[i].run;
      step            = vecs[i].step;
      halt            = vecs[i].halt;
      flush           = vecs[i].flush;
      bus.issue_ready = vecs[i].rdy;
      tick();
      chk($sformatf("v%0d_valid", i), {31'h0, bus.issue_valid}, {31'h0, vecs[i].ev});
      chk($sformatf("v%0d_instr", i), {16'h0, bus.issue_instr}, {16'h0, vecs[i].ei});
      chk($sformatf("v%0d_count", i), {28'h0, fifo_count}, {28'h0, vecs[i].ec});
      chk($sformatf("v%0d_state", i), {30'h0, state}, {30'h0, vecs[i].es});
      chk($sformatf("v%0d_wr_ready", i), {31'h0, bus.wr_ready}, {31'h0, vecs[i].ewr});
      chk($sformatf("v%0d_issued", i), {16'h0, issued_cnt}, {16'h0, vecs[i].en});
    end
    idle_inputs();
    bus.issue_ready = 1'b1;

    // Fill to full, reject a 9th write, then run all eight out
    for (int i = 0; i < 8; i++) begin
      write_one(16'h4000 + 16'(i));
      exp_q.push_back(16'h4000 + 16'(i));
      chk($sformatf("fill%0d_count", i), {28'h0, fifo_count}, i + 1);
    end
    chk("full_wr_ready", {31'h0, bus.wr_ready}, 0);
    write_one(16'h40FF);
    chk("full_reject_count", {28'h0, fifo_count}, 8);
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("full_run_state", {30'h0, state}, {30'h0, S_RUN});
    chk("full_run_wr_ready", {31'h0, bus.wr_ready}, 0);
    tick();
    chk("full_pop_count", {28'h0, fifo_count}, 7);
    chk("full_pop_wr_ready", {31'h0, bus.wr_ready}, 1);
    drain("full", 20);
    chk("full_issued", {16'h0, issued_cnt}, 15);
    chk("full_end_count", {28'h0, fifo_count}, 0);

    // Output stall in RUN holds the payload, then resumes without loss
    bus.issue_ready = 1'b0;
    write_one(16'h5001);
    write_one(16'h5002);
    write_one(16'h5003);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("stall%0d_valid", c), {31'h0, bus.issue_valid}, 1);
      chk($sformatf("stall%0d_instr", c), {16'h0, bus.issue_instr}, 32'h5001);
      chk($sformatf("stall%0d_issued", c), {16'h0, issued_cnt}, 15);
      chk($sformatf("stall%0d_count", c), {28'h0, fifo_count}, 2);
      tick();
    end
    bus.issue_ready = 1'b1;
    exp_q.push_back(16'h5001);
    exp_q.push_back(16'h5002);
    exp_q.push_back(16'h5003);
    drain("stall", 10);
    chk("stall_issued", {16'h0, issued_cnt}, 18);

    // Asynchronous reset between edges mid-RUN
    bus.issue_ready = 1'b0;
    write_one(16'h6001);
    write_one(16'h6002);
    chk("prerst_valid", {31'h0, bus.issue_valid}, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'h0, bus.issue_valid}, 0);
    chk("arst_instr", {16'h0, bus.issue_instr}, 0);
    chk("arst_state", {30'h0, state}, {30'h0, S_IDLE});
    chk("arst_issued", {16'h0, issued_cnt}, 0);
    chk("arst_count", {28'h0, fifo_count}, 0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("post_rst_wr_ready", {31'h0, bus.wr_ready}, 1);
    chk("post_rst_count", {28'h0, fifo_count}, 0);
    chk("post_rst_valid", {31'h0, bus.issue_valid}, 0);
    bus.issue_ready = 1'b1;
    run = 1'b1;
    write_one(16'h7001);
    run = 1'b0;
    chk("post_rst_state", {30'h0, state}, {30'h0, S_RUN});
    tick();
    chk("post_rst_issue_valid", {31'h0, bus.issue_valid}, 1);
    chk("post_rst_issue_instr", {16'h0, bus.issue_instr}, 32'h7001);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
